bus_strobe_sync: RTL

- Front end of xosera_main for the asynchronous 8-bit 68k-style host bus.
- Synchronises bus_cs_n_i into the clk (pixel clock) domain and captures reg_num, bytesel, rd_nwr and data on the chip-select assert edge.
- Emits single-cycle read/write strobes plus captured fields to the register/blitter stage.
- Also assembles 16-bit words from high/low byte writes so downstream register writes see a complete word.

---
 rtl/bus_strobe_sync.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/bus_strobe_sync.sv
// Host bus front end: synchronises chip select, filters glitches,
// captures bus fields and emits one strobe per accepted cycle.
module bus_strobe_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_LOW     = 2
) (
  input  logic        clk,
  input  logic        reset_n_i,
  input  logic        bus_cs_n_i,
  input  logic        bus_rd_nwr_i,
  input  logic        bus_bytesel_i,
  input  logic [3:0]  bus_reg_num_i,
  input  logic [7:0]  bus_data_i,
  output logic        write_strobe_o,
  output logic        read_strobe_o,
  output logic [3:0]  reg_num_o,
  output logic        bytesel_o,
  output logic [7:0]  data_byte_o,
  output logic        word_strobe_o,
  output logic [15:0] word_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    WAIT_REL = 2'd0,
    IDLE     = 2'd1,
    FILTER   = 2'd2,
    ACTIVE   = 2'd3
  } state_e;

  localparam logic [2:0] MIN_LOW_C = 3'(MIN_LOW);

  state_e state_q, state_d;
  logic [2:0] lowcnt_q, lowcnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic cs_s;
  logic synced;
  logic capture;

  logic        wr_stb_q;
  logic        rd_stb_q;
  logic        wd_stb_q;
  logic [3:0]  reg_q;
  logic        bsel_q;
  logic [7:0]  data_q;
  logic [7:0]  hi_q;
  logic [15:0] word_q;

  assign cs_s   = sync_q[SYNC_STAGES-1];
  // fill_q marks when cs_s holds a real sample rather than the reset value
  assign synced = fill_q[SYNC_STAGES-1];

  // Chip-select synchroniser plus fill tracker
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync_q <= '1;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus_cs_n_i};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // State and low-count register
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= WAIT_REL;
      lowcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      lowcnt_q <= lowcnt_d;
    end
  end

  // Next state: the IDLE sample counts as the first low sample, so the
  // strobe lands SYNC_STAGES + MIN_LOW edges after cs_n falls
  always_comb begin
    state_d  = state_q;
    lowcnt_d = lowcnt_q;
    capture  = 1'b0;
    unique case (state_q)
      WAIT_REL: begin
        if (synced && cs_s) state_d = IDLE;
      end
      IDLE: begin
        if (!cs_s) begin
          if (MIN_LOW_C == 3'd1) begin
            capture = 1'b1;
            state_d = ACTIVE;
          end else begin
            lowcnt_d = 3'd1;
            state_d  = FILTER;
          end
        end
      end
      FILTER: begin
        if (cs_s) begin
          state_d = IDLE;
        end else if (lowcnt_q + 3'd1 == MIN_LOW_C) begin
          capture = 1'b1;
          state_d = ACTIVE;
        end else begin
          lowcnt_d = lowcnt_q + 3'd1;
        end
      end
      ACTIVE: begin
        if (cs_s) state_d = IDLE;
      end
      default: state_d = WAIT_REL;
    endcase
  end

  // Output decode from state
  always_comb begin
    busy_o = (state_q == FILTER) || (state_q == ACTIVE);
  end

  // Field capture, strobes and word assembly
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_stb_q <= 1'b0;
      rd_stb_q <= 1'b0;
      wd_stb_q <= 1'b0;
      reg_q    <= '0;
      bsel_q   <= 1'b0;
      data_q   <= '0;
      hi_q     <= '0;
      word_q   <= '0;
    end else begin
      wr_stb_q <= capture & ~bus_rd_nwr_i;
      rd_stb_q <= capture & bus_rd_nwr_i;
      wd_stb_q <= capture & ~bus_rd_nwr_i & bus_bytesel_i;
      if (capture) begin
        reg_q  <= bus_reg_num_i;
        bsel_q <= bus_bytesel_i;
        if (!bus_rd_nwr_i) begin
          data_q <= bus_data_i;
          if (!bus_bytesel_i) hi_q <= bus_data_i;
          else word_q <= {hi_q, bus_data_i};
        end
      end
    end
  end

  assign write_strobe_o = wr_stb_q;
  assign read_strobe_o  = rd_stb_q;
  assign word_strobe_o  = wd_stb_q;
  assign reg_num_o      = reg_q;
  assign bytesel_o      = bsel_q;
  assign data_byte_o    = data_q;
  assign word_o         = word_q;

endmodule
